// File: rtl/uart_rx.sv
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. Synchronises rx, detects the start bit,
//                samples each bit at its centre and presents the byte with a
//                one-cycle o_rx_done strobe. When the UART_RX_PARITY_EN macro
//                is defined, an even-parity bit is expected between the data
//                and the stop bit, and o_parity_err reports a mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_out_data,
  output logic       o_rx_done,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  // Mid-start-bit offset and last count of a full bit period.
  localparam logic [7:0] c_HALF = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0] c_LAST = 8'(CLKS_PER_BIT - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] c_PARITY = 3'd3;
`endif
  localparam logic [2:0] c_STOP   = 3'd4;

  logic       r_s1;
  logic       r_s2;
  logic [2:0] r_state;
  logic [7:0] r_count;
  logic [2:0] r_bit_idx;
  logic [7:0] r_shift;
  logic [7:0] r_out_data;
  logic       r_rx_done;
  logic       r_frame_err;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_rx;
      r_s2 <= r_s1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;
`endif

  // Receive FSM: start qualification, bit-centre sampling, stop check.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_count      <= 8'd0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'd0;
      r_out_data   <= 8'd0;
      r_rx_done    <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_done    <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        c_IDLE: begin
          r_count   <= 8'd0;
          r_bit_idx <= 3'd0;
          if (!r_s2) begin
            r_state <= c_START;
          end
        end

        // Re-check the line half a bit in; a high line means it was a glitch.
        c_START: begin
          if (r_count < c_HALF) begin
            r_count <= r_count + 8'd1;
          end else begin
            r_count <= 8'd0;
            r_state <= r_s2 ? c_IDLE : c_DATA;
          end
        end

        c_DATA: begin
          if (r_count < c_LAST) begin
            r_count <= r_count + 8'd1;
          end else begin
            r_shift[r_bit_idx] <= r_s2;
            r_count            <= 8'd0;
            if (r_bit_idx != 3'd7) begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end else begin
              r_bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
              r_state   <= c_PARITY;
`else
              r_state   <= c_STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        c_PARITY: begin
          if (r_count < c_LAST) begin
            r_count <= r_count + 8'd1;
          end else begin
            r_par_bit <= r_s2;
            r_count   <= 8'd0;
            r_state   <= c_STOP;
          end
        end
`endif

        // Leave at mid-stop so a following start bit is seen with no dead time.
        c_STOP: begin
          if (r_count < c_LAST) begin
            r_count <= r_count + 8'd1;
          end else begin
            r_count <= 8'd0;
            r_state <= c_IDLE;
            if (r_s2) begin
              r_out_data   <= r_shift;
              r_rx_done    <= 1'b1;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= r_par_bit ^ (^r_shift);
`endif
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= c_IDLE;
          r_count <= 8'd0;
        end
      endcase
    end
  end

  assign o_out_data  = r_out_data;
  assign o_rx_done   = r_rx_done;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state != c_IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = r_parity_err;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Scoreboard bench for uart_rx. Frame tasks push the expected
//                strobe (kind, cycle, data, parity flag); a negedge monitor
//                pops and compares whenever a strobe appears.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int CPB = 4;
  localparam int H   = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Edge (counted from the edge that captures the start bit) of the stop sample.
  localparam int LAT = 4 + H + (NBITS - 1) * CPB;

  logic       clk;
  logic       rst;
  logic       i_rx;
  logic [7:0] o_out_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_parity_err;
  logic       o_busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (i_rx),
    .o_out_data   (o_out_data),
    .o_rx_done    (o_rx_done),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    bit         perr;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_err    = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (o_rx_done || o_frame_err || o_parity_err) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_strobe: rx_done=%0b frame_err=%0b parity_err=%0b, expected none (cycle %0d)",
                 o_rx_done, o_frame_err, o_parity_err, cyc);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind", {30'd0, o_frame_err, o_rx_done}, e.ferr ? 32'd2 : 32'd1);
        chk("strobe_cycle", cyc, e.cyc);
        chk("out_data", {24'd0, o_out_data}, {24'd0, e.data});
        chk("parity_err", {31'd0, o_parity_err}, {31'd0, e.perr});
      end
    end
  end

  task automatic drive_bit(input logic b);
    i_rx = b;
    repeat (CPB) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one frame starting right now (caller is just past a posedge).
  task automatic send(input logic [7:0] d, input bit stop_b, input bit par_b);
    exp_t e;
    e.ferr = !stop_b;
    if (stop_b) last_good = d;
    e.data = last_good;
`ifdef UART_RX_PARITY_EN
    e.perr = stop_b && (par_b != (^d));
`else
    e.perr = 1'b0;
`endif
    e.cyc = cyc + LAT;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b);
`endif
    drive_bit(stop_b);
    i_rx = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         nbusy;
    logic [7:0] d;
    rst  = 1'b1;
    i_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_data",   {24'd0, o_out_data}, 32'h00);
    chk("reset_rx_done",    {31'd0, o_rx_done}, 0);
    chk("reset_frame_err",  {31'd0, o_frame_err}, 0);
    chk("reset_parity_err", {31'd0, o_parity_err}, 0);
    chk("reset_busy",       {31'd0, o_busy}, 0);
    rst = 1'b0;
    idle(4);

    // Basic byte; stop sample at edge 41 with CPB=4 and no parity.
    send(8'hA5, 1'b1, ^8'hA5);
    drain();
    idle(5);

    // Back-to-back frames with no idle gap.
    send(8'h00, 1'b1, ^8'h00);
    send(8'hFF, 1'b1, ^8'hFF);
    send(8'h3C, 1'b1, ^8'h3C);
    drain();
    idle(5);

    // One-clock glitch: short busy, no strobe, data held.
    i_rx = 1'b0;
    @(posedge clk);
    #1;
    i_rx = 1'b1;
    nbusy = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_busy) nbusy++;
    end
    chk("glitch_busy_seen", {31'd0, (nbusy >= 1)}, 1);
    chk("glitch_busy_short", {31'd0, (nbusy <= H + 2)}, 1);
    chk("glitch_hold", {24'd0, o_out_data}, {24'd0, last_good});
    @(posedge clk);
    #1;

    // Frame error: stop bit low, out_data keeps 8'h3C.
    send(8'h5A, 1'b0, ^8'h5A);
    drain();
    idle(10);
    chk("ferr_hold", {24'd0, o_out_data}, 32'h3C);

    // Reset during data bit 3, then a clean 8'h81.
    d = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    i_rx = d[3];
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    i_rx = 1'b1;
    last_good = 8'h00;
    chk("midrst_out_data",   {24'd0, o_out_data}, 32'h00);
    chk("midrst_busy",       {31'd0, o_busy}, 0);
    chk("midrst_rx_done",    {31'd0, o_rx_done}, 0);
    chk("midrst_frame_err",  {31'd0, o_frame_err}, 0);
    chk("midrst_parity_err", {31'd0, o_parity_err}, 0);
    idle(4);
    send(8'h81, 1'b1, ^8'h81);
    drain();
    idle(5);

`ifdef UART_RX_PARITY_EN
    // Even parity: correct bit 1 for 8'h07, then a wrong bit 0.
    send(8'h07, 1'b1, 1'b1);
    drain();
    idle(5);
    send(8'h07, 1'b1, 1'b0);
    drain();
    idle(5);
`endif

    idle(20);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver: the receive end of the 8N1 link driven by the team's UART transmitter. It synchronises the asynchronous `rx` line and detects the start bit. It samples each bit at its centre using a per-bit clock counter, shifts the data in LSB-first and presents the completed byte with a one-cycle `rx_done` strobe. It sits between the pad and the host-side byte consumer, and uses the same `CLKS_PER_BIT` baud setting as the transmitter.

## Interface
- `CLKS_PER_BIT`, default 4: clk cycles per serial bit. Legal range is 2..255. The counter is 8 bits wide.
- `clk`  in  1: clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `rx`  in  1: asynchronous serial input; idles high.
- `out_data`  out  8: last correctly framed byte; holds until the next good frame.
- `rx_done`  out  1: one-cycle pulse when `out_data` is updated.
- `frame_err`  out  1: one-cycle pulse when the stop bit is sampled low.
- `parity_err`  out  1: one-cycle pulse on parity mismatch. Tied 0 without `UART_RX_PARITY_EN`.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- Input sync: `rx` passes through 2 flops, `s1` then `s2`. Both reset to 1. All FSM decisions use `s2`.
- H = (CLKS_PER_BIT-1)/2, using integer division.
- States are IDLE, START, DATA, PARITY (macro only) and STOP. Reset enters IDLE with count=0 and bit_idx=0.
- IDLE: count=0, bit_idx=0. If `s2`==0, go to START.
- START: while count<H, increment count. At count==H:
  - if `s2`==0: count=0, go to DATA;
  - if `s2`==1 (glitch): return to IDLE with no strobe.
- DATA: while count<CLKS_PER_BIT-1, increment count. At count==CLKS_PER_BIT-1:
  - shift[bit_idx]=`s2`, count=0;
  - if bit_idx<7: bit_idx++;
  - else: bit_idx=0, go to PARITY (macro) or STOP.
- PARITY: same count rule as DATA. At the final count, capture the parity bit, set count=0 and go to STOP.
- STOP: same count rule. At the final count, go to IDLE and evaluate:
  - `s2`==1: `out_data`=shift and `rx_done`=1 for one cycle.
  - `s2`==0: `frame_err`=1 for one cycle. `out_data` is unchanged and `rx_done` stays 0.
- Returning to IDLE at the mid-stop sample allows a following start bit to be accepted with no dead time.
- Widths: the count compare is unsigned 8-bit. bit_idx is 3 bits and never wraps past 7.

## Timing
- Reset values: `out_data`=8'h00; `rx_done`, `frame_err`, `parity_err` and `busy` all 0.
- Edge numbering: edge 1 is the first rising edge at which `rx`=0 is captured into `s1`.
  - Edge 3: IDLE moves to START; `busy` is high after this edge.
  - Edge 4+H: START moves to DATA.
  - Edge 4+H+(i+1)·CLKS_PER_BIT: data bit i is sampled.
  - Edge 4+H+9·CLKS_PER_BIT: stop bit is sampled; `rx_done` or `frame_err` is high for the following cycle. Add CLKS_PER_BIT with parity.
  - With CLKS_PER_BIT=4 and no parity, this is edge 41.
- Strobes are registered. They are never high in two consecutive cycles for a single frame.
- `rst` mid-frame: the next edge returns to IDLE and clears the strobes, `busy` and `out_data`. The partial byte is discarded.
- `rx` is held low (break): `frame_err` pulses, the FSM returns to IDLE and immediately re-enters START, with no `rx_done`.

## Configuration
- `UART_RX_PARITY_EN`, defined: the frame is 11 bits (start, 8 data, even parity, stop) and the PARITY state is present.
  - The expected parity bit is the XOR of the 8 data bits.
  - On a mismatch with a good stop bit, `parity_err` pulses in the same cycle as `rx_done`, and `out_data` is still updated.
- Undefined: the frame is 10-bit 8N1, the PARITY state is absent and `parity_err` is constant 0.

## Test plan
- Basic byte: CLKS_PER_BIT=4, drive an 8N1 frame for 8'hA5 with the falling edge captured at edge 1.
  - Required: `rx_done` high for exactly the cycle after edge 41, `out_data`=8'hA5, `frame_err`=0.
- Back-to-back: frames for 8'h00, 8'hFF and 8'h3C with no idle gap. Required: three `rx_done` pulses with those values, in order.
- Glitch: `rx` low for 1 clk, then high. Required: `busy` pulses for ≤H+2 cycles, no strobes, `out_data` unchanged.
- Frame error: 8'h5A with the stop bit forced to 0. Required: `frame_err` pulse at the stop-sample cycle, no `rx_done`, `out_data` keeps its previous value.
- Reset mid-frame: assert `rst` for 1 cycle during bit 3, then send 8'h81. Required: all outputs 0 after reset, then `rx_done` with 8'h81.
- Parity (macro on): 8'h07 with parity bit 1, then 8'h07 with parity bit 0.
  - Required: the first frame gives `rx_done` with `parity_err`=0.
  - The second gives `rx_done` with `parity_err`=1.
  - `out_data`=8'h07 both times.
